pkt_buf_reader: RTL and testbench

Read-side sequencer for the packet sample buffer. Upstream logic fills one bank of a 2^ADDR_W-byte dual-port RAM and requests transmission. This block then drives the RAM read port (registered output, 1-cycle latency), buffers the returned bytes and presents them as a valid/ready byte stream with a last marker. It sits between the dual-port sample RAM and the Ethernet frame builder, and sustains one byte per cycle when the sink is always ready.

---
 rtl/pkt_buf_pkg.sv | 20 ++
 rtl/byte_fifo.sv | 61 ++++++
 rtl/pkt_buf_reader.sv | 166 ++++++++++++++++
 tb/tb_pkt_buf_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_buf_pkg.sv
// Shared types and constants for the packet sample buffer read path.
package pkt_buf_pkg;

   localparam int unsigned FIFO_DEPTH_DEFAULT = 4;
   localparam int unsigned BYTE_W             = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // One buffered stream beat: byte plus end-of-request marker.
   typedef struct packed {
      logic              last;
      logic [BYTE_W-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/byte_fifo.sv
// Small shift-register FIFO of stream beats; entry 0 is always the head, so the
// head data, valid and count all come straight from flops.
module byte_fifo
   import pkt_buf_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_push,
   input  fifo_entry_t   i_wdata,
   input  logic          i_pop,
   output fifo_entry_t   o_head,
   output logic          o_valid,
   output logic [CW-1:0] o_count
);

   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fifo_entry_t   r_mem [DEPTH];
   logic [CW-1:0] r_count;
   logic          r_valid;

   logic          w_pop;
   logic          w_push;
   logic [CW-1:0] w_count_nxt;
   logic [IW-1:0] w_wr_idx;

   assign w_pop       = i_pop && r_valid;
   assign w_push      = i_push && ((r_count < CW'(DEPTH)) || w_pop);
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
   // A simultaneous pop shifts everything down, so the write slot moves with it.
   assign w_wr_idx    = IW'(r_count - CW'(w_pop));

   always_ff @(posedge clk) begin
      if (w_pop) begin
         for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            r_mem[i] <= r_mem[i+1];
         end
      end
      if (w_push) begin
         r_mem[w_wr_idx] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
         r_valid <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_valid <= (w_count_nxt != '0);
      end
   end

   assign o_head  = r_mem[0];
   assign o_valid = r_valid;
   assign o_count = r_count;

endmodule

// File: rtl/pkt_buf_reader.sv
// Read-side sequencer for the packet sample buffer: walks one RAM bank and
// streams the bytes out as valid/ready beats with a last marker.
module pkt_buf_reader
   import pkt_buf_pkg::*;
#(
   parameter int unsigned ADDR_W     = 14,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              bank,
   input  logic [ADDR_W-1:0] len,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        ram_data,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              start_err
);

   localparam int unsigned OFF_W = ADDR_W - 1;
   localparam int unsigned BANK  = 1 << OFF_W;
   localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SW    = CW + 1;

   state_t            r_state;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [OFF_W-1:0]  r_offset;
   logic [ADDR_W-1:0] r_len_q;
   logic              r_bank_q;
   logic              r_all_issued;
   logic              r_v1;
   logic              r_l1;
   logic              r_v2;
   logic              r_l2;
   logic              r_busy;
   logic              r_done;
   logic              r_start_err;

   logic [ADDR_W-1:0] w_len_c;
   logic [1:0]        w_inflight;
   logic [CW-1:0]     w_fifo_count;
   logic              w_fifo_valid;
   fifo_entry_t       w_head;
   fifo_entry_t       w_wdata;
   logic              w_pop;
   logic              w_room;
   logic              w_is_last;
   logic              w_drain_done;

   assign w_len_c    = (len > ADDR_W'(BANK)) ? ADDR_W'(BANK) : len;
   // r_v1: address on the RAM port this cycle; r_v2: its data is on ram_data now.
   assign w_inflight = {1'b0, r_v1} + {1'b0, r_v2};
   assign w_pop      = w_fifo_valid && out_ready;
   assign w_room     = (SW'(w_fifo_count) + SW'(w_inflight)) < SW'(FIFO_DEPTH);
   assign w_is_last  = (ADDR_W'(r_offset) == (r_len_q - ADDR_W'(1)));
   // Leave DRAIN on the edge that pops the final byte so done lands one cycle later.
   assign w_drain_done = (w_inflight == 2'd0) &&
                         ((w_fifo_count == '0) || ((w_fifo_count == CW'(1)) && w_pop));
   assign w_wdata    = '{last: r_l2, data: ram_data};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_ram_addr   <= '0;
         r_offset     <= '0;
         r_len_q      <= '0;
         r_bank_q     <= 1'b0;
         r_all_issued <= 1'b0;
         r_v1         <= 1'b0;
         r_l1         <= 1'b0;
         r_v2         <= 1'b0;
         r_l2         <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_start_err  <= 1'b0;
      end else begin
         r_done      <= 1'b0;
         r_v1        <= 1'b0;
         r_l1        <= 1'b0;
         r_v2        <= r_v1;
         r_l2        <= r_l1;
         r_start_err <= start && (r_state != ST_IDLE);

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_bank_q <= bank;
                  r_len_q  <= w_len_c;
                  if (w_len_c == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     // First read goes out with the accept to hit cycle-1 addressing.
                     r_state      <= ST_READ;
                     r_busy       <= 1'b1;
                     r_ram_addr   <= {bank, OFF_W'(0)};
                     r_v1         <= 1'b1;
                     r_l1         <= (w_len_c == ADDR_W'(1));
                     r_all_issued <= (w_len_c == ADDR_W'(1));
                     r_offset     <= (w_len_c == ADDR_W'(1)) ? OFF_W'(0) : OFF_W'(1);
                  end
               end
            end

            ST_READ: begin
               if (r_all_issued) begin
                  r_state <= ST_DRAIN;
               end else if (w_room) begin
                  r_ram_addr <= {r_bank_q, r_offset};
                  r_v1       <= 1'b1;
                  r_l1       <= w_is_last;
                  if (w_is_last) begin
                     r_all_issued <= 1'b1;
                  end else begin
                     r_offset <= r_offset + OFF_W'(1);
                  end
               end
            end

            ST_DRAIN: begin
               if (w_drain_done) begin
                  r_state      <= ST_DONE;
                  r_busy       <= 1'b0;
                  r_done       <= 1'b1;
                  r_all_issued <= 1'b0;
               end
            end

            ST_DONE: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (r_v2),
      .i_wdata (w_wdata),
      .i_pop   (out_ready),
      .o_head  (w_head),
      .o_valid (w_fifo_valid),
      .o_count (w_fifo_count)
   );

   assign ram_addr  = r_ram_addr;
   assign out_data  = w_head.data;
   assign out_last  = w_head.last;
   assign out_valid = w_fifo_valid;
   assign busy      = r_busy;
   assign done      = r_done;
   assign start_err = r_start_err;

endmodule

// File: tb/tb_pkt_buf_reader.sv
// Directed bench for pkt_buf_reader with a behavioural 1-cycle-latency RAM.
module tb_pkt_buf_reader;

   localparam int unsigned ADDR_W = 14;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              bank;
   logic [ADDR_W-1:0] len;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_data;
   logic [7:0]        out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              busy;
   logic              done;
   logic              start_err;

   always #5 clk = ~clk;

   pkt_buf_reader #(
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .bank      (bank),
      .len       (len),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .start_err (start_err)
   );

   function automatic logic [7:0] exp_byte(input int a);
      return 8'((a + 16) ^ (a >> 8));
   endfunction

   logic [7:0] mem [1 << ADDR_W];
   always @(posedge clk) ram_data <= mem[ram_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: everything observed at the falling edge.
   logic [7:0] q_data [$];
   bit         q_last [$];
   int         q_cyc  [$];
   int done_cnt = 0, done_cyc = 0, err_cnt = 0, busy_cnt = 0, valid_cnt = 0;
   int acc_total = 0, max_gap = 0;
   bit busy_at_done = 1'b0;
   bit trk_en = 1'b0;
   int trk_base = 0, trk_acc0 = 0;

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         q_data.push_back(out_data);
         q_last.push_back(out_last);
         q_cyc.push_back(cyc);
         acc_total++;
      end
      if (done) begin
         done_cnt++;
         done_cyc     = cyc;
         busy_at_done = busy;
      end
      if (start_err) err_cnt++;
      if (busy) busy_cnt++;
      if (out_valid) valid_cnt++;
      if (trk_en && busy) begin
         int gap;
         gap = (int'(ram_addr) - trk_base + 1) - (acc_total - trk_acc0);
         if (gap > max_gap) max_gap = gap;
      end
   end

   int n_checks = 0, n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic b, input int l, output int s_cyc);
      start = 1'b1;
      bank  = b;
      len   = ADDR_W'(l);
      s_cyc = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget, input bit rnd, input string tag);
      for (int i = 0; i < budget; i++) begin
         if (done_cnt > d0) break;
         if (rnd) out_ready = ($urandom_range(99) < 30);
         tick();
      end
      out_ready = 1'b1;
      check_eq({tag, " done seen"}, 32'(done_cnt > d0), 32'd1);
   endtask

   task automatic check_stream(input string tag, input int q0, input int n, input int a0,
                               input int s_cyc, input bit strict);
      int got_n;
      got_n = q_data.size() - q0;
      check_eq({tag, " count"}, 32'(got_n), 32'(n));
      for (int i = 0; i < n && i < got_n; i++) begin
         check_eq($sformatf("%s byte %0d", tag, i), 32'(q_data[q0+i]), 32'(exp_byte(a0 + i)));
         check_eq($sformatf("%s last %0d", tag, i), 32'(q_last[q0+i]), 32'(i == n - 1));
      end
      if (strict && got_n == n && n > 0) begin
         check_eq({tag, " first cycle"}, 32'(q_cyc[q0] - s_cyc), 32'd3);
         check_eq({tag, " last cycle"}, 32'(q_cyc[q0+n-1] - s_cyc), 32'(n + 2));
         check_eq({tag, " done cycle"}, 32'(done_cyc - s_cyc), 32'(n + 3));
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, sd, d0, e0, q0, b0, v0;
      for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = exp_byte(a);
      reset = 1'b1; start = 1'b0; bank = 1'b0; len = '0; out_ready = 1'b1;
      repeat (3) tick();

      check_eq("rst out_valid", 32'(out_valid), 32'd0);
      check_eq("rst out_last", 32'(out_last), 32'd0);
      check_eq("rst busy", 32'(busy), 32'd0);
      check_eq("rst done", 32'(done), 32'd0);
      check_eq("rst start_err", 32'(start_err), 32'd0);
      check_eq("rst ram_addr", 32'(ram_addr), 32'd0);
      reset = 1'b0;
      tick();

      // Basic: bank 0, four bytes 0x10..0x13, sink always ready.
      d0 = done_cnt; q0 = q_data.size();
      pulse_start(1'b0, 4, s);
      wait_done(d0, 50, 1'b0, "basic");
      check_stream("basic", q0, 4, 0, s, 1'b1);
      if (q_data.size() >= q0 + 4) begin
         check_eq("basic lit first", 32'(q_data[q0]), 32'h10);
         check_eq("basic lit last", 32'(q_data[q0+3]), 32'h13);
      end
      check_eq("basic busy at done", 32'(busy_at_done), 32'd0);
      repeat (3) tick();
      check_eq("basic done count", 32'(done_cnt - d0), 32'd1);

      // Random backpressure, bank 1, len 100.
      d0 = done_cnt; q0 = q_data.size();
      trk_base = 'h2000; trk_acc0 = acc_total; trk_en = 1'b1;
      pulse_start(1'b1, 100, s);
      check_eq("rand first addr", 32'(ram_addr), 32'h2000);
      wait_done(d0, 3000, 1'b1, "rand");
      trk_en = 1'b0;
      check_stream("rand", q0, 100, 'h2000, s, 1'b0);
      check_eq("rand outstanding<=4", 32'(max_gap <= 4), 32'd1);
      repeat (3) tick();
      check_eq("rand done count", 32'(done_cnt - d0), 32'd1);

      // Zero length: done in cycle 1, nothing else.
      d0 = done_cnt; b0 = busy_cnt; v0 = valid_cnt;
      pulse_start(1'b0, 0, s);
      repeat (4) tick();
      check_eq("zero done count", 32'(done_cnt - d0), 32'd1);
      check_eq("zero done cycle", 32'(done_cyc - s), 32'd1);
      check_eq("zero busy cycles", 32'(busy_cnt - b0), 32'd0);
      check_eq("zero valid cycles", 32'(valid_cnt - v0), 32'd0);

      // Collision: second start 5 cycles into a 20-byte transfer.
      d0 = done_cnt; e0 = err_cnt; q0 = q_data.size();
      pulse_start(1'b0, 20, s);
      repeat (4) tick();
      pulse_start(1'b1, 3, sd);
      wait_done(d0, 100, 1'b0, "collide");
      check_stream("collide", q0, 20, 0, s, 1'b1);
      repeat (10) tick();
      check_eq("collide start_err", 32'(err_cnt - e0), 32'd1);
      check_eq("collide done count", 32'(done_cnt - d0), 32'd1);

      // Full bank 1.
      d0 = done_cnt; q0 = q_data.size();
      pulse_start(1'b1, 8192, s);
      wait_done(d0, 9000, 1'b0, "full");
      check_stream("full", q0, 8192, 'h2000, s, 1'b1);
      check_eq("full final addr", 32'(ram_addr), 32'h3FFF);

      // Clamp: 9000 requested from bank 0.
      d0 = done_cnt; q0 = q_data.size();
      pulse_start(1'b0, 9000, s);
      wait_done(d0, 9000, 1'b0, "clamp");
      check_stream("clamp", q0, 8192, 0, s, 1'b1);
      check_eq("clamp final addr", 32'(ram_addr), 32'h1FFF);

      // Reset mid-stream after 5 bytes, then a short clean request.
      d0 = done_cnt; q0 = q_data.size();
      pulse_start(1'b0, 50, s);
      for (int i = 0; i < 100; i++) begin
         if (q_data.size() - q0 >= 5) break;
         tick();
      end
      check_eq("midrst reached 5", 32'(q_data.size() - q0 >= 5), 32'd1);
      reset = 1'b1;
      tick();
      check_eq("midrst out_valid", 32'(out_valid), 32'd0);
      check_eq("midrst busy", 32'(busy), 32'd0);
      reset = 1'b0;
      repeat (6) tick();
      check_eq("midrst no done", 32'(done_cnt - d0), 32'd0);
      d0 = done_cnt; q0 = q_data.size();
      pulse_start(1'b0, 2, s);
      wait_done(d0, 50, 1'b0, "postrst");
      check_stream("postrst", q0, 2, 0, s, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
